// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: single-clock AHB-to-APB bridge with one-hot slave select.
// Define AHB2APB_PSLVERR_EN to turn PSLVERR and unmapped slaves into a two-cycle AHB ERROR.
module ahb_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLAVES_NUM     = 4,
  parameter int SLAVE_ADDR_LSB = 12
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic                             HSEL,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  input  logic                             HWRITE,
  input  logic                             HREADY,
  input  logic [DATA_WIDTH-1:0]            HWDATA,
  output logic                             HREADYOUT,
  output logic                             HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [SLAVES_NUM-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA,
  input  logic [SLAVES_NUM-1:0]            PREADY,
  input  logic [SLAVES_NUM-1:0]            PSLVERR
);
  localparam int SIDX_W = SLAVES_NUM > 1 ? $clog2(SLAVES_NUM) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;
  state_t state, state_nx;
  logic [SIDX_W-1:0] idx;
  logic valid, rdy, err, accept, unused_ok;
  assign valid = 32'(idx) < SLAVES_NUM;
  assign rdy = valid ? PREADY[idx] : 1'b1;
`ifdef AHB2APB_PSLVERR_EN
  assign err = !valid || PSLVERR[idx];
`else
  assign err = 1'b0;
`endif
  assign unused_ok = ^{HTRANS[0], PSLVERR};
  // A new transfer may overlap the completing ACCESS cycle so back-to-back accesses skip IDLE.
  assign accept = HSEL && HREADY && HTRANS[1] &&
                  (state == IDLE || state == ERR2 || (state == ACCESS && rdy && !err));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ERR2: state_nx = accept ? SETUP : IDLE;
      SETUP:      state_nx = ACCESS;
      ACCESS:     state_nx = !rdy ? ACCESS : err ? ERR1 : accept ? SETUP : IDLE;
      ERR1:       state_nx = ERR2;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state  <= IDLE;
      idx    <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        idx    <= HADDR[SLAVE_ADDR_LSB +: SIDX_W];
      end
    end
  // The erroring ACCESS cycle keeps HREADYOUT low so ERROR spans ERR1 (wait) and ERR2 (done).
  assign PSEL      = (state == SETUP || state == ACCESS) && valid ? SLAVES_NUM'(1) << idx : '0;
  assign PENABLE   = state == ACCESS;
  assign HREADYOUT = state == SETUP || state == ERR1 ? 1'b0 : state == ACCESS ? rdy && !err : 1'b1;
  assign HRESP     = state == ERR1 || state == ERR2;
  assign HRDATA    = state == ACCESS && valid ? PRDATA[int'(idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign PWDATA    = HWDATA;
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed table, corner sequences and random transfers for ahb_apb_bridge.
module tb_ahb_apb_bridge;
`ifdef AHB2APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0] HTRANS = '0;
  logic HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [31:0] HRDATA, PADDR, PWDATA;
  logic [3:0] PSEL, PREADY = '0, PSLVERR = '0;
  logic [127:0] PRDATA = '0;
  logic [31:0] prd [4];
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic [3:0]  exp_psel;
    int          exp_lat;
    logic        exp_resp;
  } rec_t;
  rec_t tbl [6];
  ahb_apb_bridge dut (
    .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic load_prd(input int sel, input logic [31:0] v);
    for (int i = 0; i < 4; i++) prd[i] = $urandom;
    prd[sel] = v;
    PRDATA = {prd[3], prd[2], prd[1], prd[0]};
  endtask
  // Caller positions time just after a rising edge (or mid-cycle); returns just after a rising edge.
  task automatic run(input rec_t r);
    int lat;
    logic prev_resp, c_pen, c_resp;
    logic [3:0] c_psel;
    logic [31:0] c_rdata, c_pwdata;
    lat = -1;
    prev_resp = 1'b0;
    c_pen = 1'b0; c_resp = 1'b0; c_psel = '0; c_rdata = '0; c_pwdata = '0;
    load_prd(int'(r.addr[13:12]), r.rdata);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = r.addr; HWRITE = r.write; HWDATA = $urandom;
    PREADY = '0; PSLVERR = r.err ? 4'hF : 4'h0;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = r.data;
    @(negedge clk);
    chk("setup_psel", PSEL, r.exp_psel);
    chk("setup_penable", PENABLE, 0);
    chk("setup_hreadyout", HREADYOUT, 0);
    chk("setup_paddr", PADDR, r.addr);
    chk("setup_pwrite", PWRITE, r.write);
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      PREADY = (k >= 1 + r.waits) ? 4'hF : 4'h0;
      @(negedge clk);
      if (HREADYOUT) begin
        lat = k; c_psel = PSEL; c_pen = PENABLE; c_resp = HRESP;
        c_rdata = HRDATA; c_pwdata = PWDATA;
      end else prev_resp = HRESP;
    end
    chk("latency", 64'(lat), 64'(r.exp_lat));
    chk("done_hresp", c_resp, r.exp_resp);
    if (r.exp_resp) chk("err1_hresp", prev_resp, 1);
    else begin
      chk("done_psel", c_psel, r.exp_psel);
      chk("done_penable", c_pen, 1);
      if (r.write) chk("pwdata", c_pwdata, r.data);
      else chk("hrdata", c_rdata, r.rdata);
    end
    @(posedge clk); #1;
    PREADY = '0; PSLVERR = '0;
    @(negedge clk);
    chk("idle_psel", PSEL, 0);
    chk("idle_hreadyout", HREADYOUT, 1);
    chk("idle_hresp", HRESP, 0);
    chk("idle_hrdata", HRDATA, 0);
    chk("hold_paddr", PADDR, r.addr);
    chk("hold_pwrite", PWRITE, r.write);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rec_t r;
    tbl[0] = '{32'h0000_2010, 1'b1, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 4'b0100, 1, 1'b0};
    tbl[1] = '{32'h0000_1004, 1'b0, 32'h0, 32'h1234_5678, 3, 1'b0, 4'b0010, 4, 1'b0};
    tbl[2] = '{32'h0000_0008, 1'b1, 32'h0BAD_F00D, 32'h0, 1, 1'b0, 4'b0001, 2, 1'b0};
    tbl[3] = '{32'hABCD_3FFC, 1'b0, 32'h0, 32'h5A5A_A5A5, 0, 1'b0, 4'b1000, 1, 1'b0};
    tbl[4] = '{32'h0000_1000, 1'b0, 32'h0, 32'hCAFE_0001, 0, 1'b1, 4'b0010, ERR_EN ? 3 : 1, ERR_EN};
    tbl[5] = '{32'h0000_3020, 1'b1, 32'h7777_1111, 32'h0, 2, 1'b1, 4'b1000, ERR_EN ? 5 : 3, ERR_EN};
    @(negedge clk);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    chk("rst_hrdata", HRDATA, 0);
    HRESET = 1'b0;
    foreach (tbl[i]) run(tbl[i]);
    load_prd(3, 32'h3333_CCCC);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0040; HWRITE = 1'b1; PREADY = '0;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hA5A5_0001;
    @(posedge clk); #1;
    PREADY = 4'hF; HSEL = 1'b1; HTRANS = 2'b11; HADDR = 32'h0000_3008; HWRITE = 1'b0;
    @(negedge clk);
    chk("b2b_hreadyout1", HREADYOUT, 1);
    chk("b2b_psel1", PSEL, 4'b0001);
    chk("b2b_pwdata1", PWDATA, 32'hA5A5_0001);
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; PREADY = '0;
    @(negedge clk);
    chk("b2b_setup2_psel", PSEL, 4'b1000);
    chk("b2b_setup2_penable", PENABLE, 0);
    chk("b2b_setup2_paddr", PADDR, 32'h0000_3008);
    chk("b2b_setup2_pwrite", PWRITE, 0);
    @(posedge clk); #1;
    PREADY = 4'hF;
    @(negedge clk);
    chk("b2b_hreadyout2", HREADYOUT, 1);
    chk("b2b_hrdata2", HRDATA, 32'h3333_CCCC);
    @(posedge clk); #1;
    PREADY = '0;
    @(negedge clk);
    chk("b2b_idle_psel", PSEL, 0);
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_2000; HWRITE = 1'b1;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b10;
    @(negedge clk);
    chk("busy_psel", PSEL, 0);
    chk("busy_hreadyout", HREADYOUT, 1);
    chk("busy_paddr_hold", PADDR, 32'h0000_3008);
    @(posedge clk); #1;
    HTRANS = 2'b00;
    @(negedge clk);
    chk("nosel_psel", PSEL, 0);
    chk("nosel_hresp", HRESP, 0);
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_1100; HWRITE = 1'b1; PREADY = '0;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("mid_penable", PENABLE, 1);
    #2 HRESET = 1'b1;
    #1;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_hreadyout", HREADYOUT, 1);
    chk("mid_rst_paddr", PADDR, 0);
    @(negedge clk);
    HRESET = 1'b0;
    run('{32'h0000_2004, 1'b1, 32'h1357_9BDF, 32'h0, 0, 1'b0, 4'b0100, 1, 1'b0});
    for (int n = 0; n < 40; n++) begin
      int s;
      s = $urandom_range(0, 3);
      r.addr = ($urandom & 32'hFFFF_CFFC) | (32'(s) << 12);
      r.write = 1'($urandom);
      r.data = $urandom;
      r.rdata = $urandom;
      r.waits = $urandom_range(0, 3);
      r.err = $urandom_range(0, 3) == 0;
      r.exp_psel = 4'b0001 << s;
      r.exp_resp = r.err && ERR_EN;
      r.exp_lat = (r.exp_resp ? 3 : 1) + r.waits;
      run(r);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
